// File: rtl/gatelevel_addsub_seq.sv
// Nibble-serial W-bit adder/subtractor: one 4-bit gate-level add/sub slice reused
// over N_NIB clocks, LSB nibble first, with a registered result presented on DONE.
module gatelevel_addsub_seq #(
  parameter int N_NIB = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Op,
  input  logic [4*N_NIB-1:0] A,
  input  logic [4*N_NIB-1:0] B,
  output logic [4*N_NIB-1:0] Ans,
  output logic               Carry,
  output logic               Ovf,
  output logic               Busy,
  output logic               Done
);

  localparam int W     = 4 * N_NIB;
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [W-1:0]     a_reg, b_reg;
  logic             op_reg;
  logic [W-1:0]     shadow_reg;
  logic [W-1:0]     ans_reg;
  logic             carry_out_reg;
  logic             ovf_reg;

  logic             accept;
  logic             step;
  logic             last;

  // Operand nibble views so the slice can be steered by the running index.
  logic [3:0] a_nibs [N_NIB];
  logic [3:0] b_nibs [N_NIB];
  logic [3:0] a_nib, b_nib, b_x;
  logic [3:0] gen, prop, sum;
  logic [4:0] c;
  logic [W-1:0] shadow_next;
  logic       ovf_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_NIB; gi++) begin : g_nib_view
      assign a_nibs[gi] = a_reg[gi*4 +: 4];
      assign b_nibs[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  assign a_nib = a_nibs[idx_reg];
  assign b_nib = b_nibs[idx_reg];
  assign last  = (idx_reg == IDX_W'(N_NIB - 1));

  // Gate-level ripple slice: B inverted by Op, carry chained from the carry register.
  assign c[0] = carry_reg;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign b_x[gi]   = b_nib[gi] ^ op_reg;
      assign gen[gi]   = a_nib[gi] & b_x[gi];
      assign prop[gi]  = a_nib[gi] ^ b_x[gi];
      assign sum[gi]   = prop[gi] ^ c[gi];
      assign c[gi + 1] = gen[gi] | (prop[gi] & c[gi]);
    end
  endgenerate

  generate
    for (gi = 0; gi < N_NIB; gi++) begin : g_shadow_next
      assign shadow_next[gi*4 +: 4] =
        (idx_reg == IDX_W'(gi)) ? sum : shadow_reg[gi*4 +: 4];
    end
  endgenerate

  // Only meaningful on the last nibble, where sum[3] is the result's sign bit.
  assign ovf_next = (a_reg[W-1] ^ sum[3]) & ((b_reg[W-1] ^ op_reg) ^ sum[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= 1'b0;
      shadow_reg    <= '0;
      ans_reg       <= '0;
      carry_out_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      op_reg    <= Op;
      carry_reg <= Op;
      idx_reg   <= '0;
    end else if (step) begin
      shadow_reg <= shadow_next;
      carry_reg  <= c[4];
      if (last) begin
        // Commit the whole word at once so partial sums never reach Ans.
        idx_reg       <= '0;
        ans_reg       <= shadow_next;
        carry_out_reg <= c[4];
        ovf_reg       <= ovf_next;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign Ans   = ans_reg;
  assign Carry = carry_out_reg;
  assign Ovf   = ovf_reg;
  assign Busy  = (state_reg == RUN);
  assign Done  = (state_reg == DONE);

endmodule

// File: tb/tb_gatelevel_addsub_seq.sv
// Self-checking bench for gatelevel_addsub_seq (N_NIB = 4): directed corner cases,
// randomized operations against an integer-arithmetic model, hold, back-to-back and reset.
module tb_gatelevel_addsub_seq;

  localparam int N_NIB = 4;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Start = 1'b0;
  logic         Op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Ans;
  logic         Carry, Ovf, Busy, Done;

  int n_tests = 0;
  int n_fail  = 0;

  gatelevel_addsub_seq #(.N_NIB(N_NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Ans   (Ans),
    .Carry (Carry),
    .Ovf   (Ovf),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic, not the nibble datapath.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    int sa, sb, sr, ua, ub;
    logic [W-1:0] r;
    logic cy, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    sr = op ? (sa - sb) : (sa + sb);
    r  = op ? W'(ua - ub) : W'(ua + ub);
    cy = op ? (ua >= ub) : ((ua + ub) > 65535);
    ov = (sr > 32767) || (sr < -32768);
    return {cy, ov, r};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    @(negedge clk);
    A = a; B = b; Op = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Called at the negedge following the accepting edge; counts edges to Done.
  task automatic wait_done(output int edges, output int busy_cycles, output bit ans_moved);
    logic [W-1:0] ans0;
    ans0 = Ans;
    edges = 0;
    busy_cycles = 0;
    ans_moved = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (Busy) busy_cycles++;
      @(negedge clk);
      edges = k;
      if (Done) break;
      if (Ans !== ans0) ans_moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({Ans, Carry, Ovf, Busy, Done} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h required 0", {Ans, Carry, Ovf, Busy, Done});
    end
    Start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({Ans, Carry, Ovf, Busy, Done} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required 0", {Ans, Carry, Ovf, Busy, Done});
    end
    @(negedge clk);
    Start = 1'b0;
    rst = 1'b0;
    $display("[TB] reset released, outputs idle");
  endtask

  task automatic test_directed;
    logic [W-1:0] va [6] = '{16'h1234, 16'h0005, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic [W-1:0] vb [6] = '{16'h0FF1, 16'h0007, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic         vo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] req [6] = '{{2'b00, 16'h2225}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF},
                              {2'b01, 16'h8000}, {2'b10, 16'h0000}, {2'b00, 16'hFFFF}};
    int edges, busy_c;
    bit moved;
    for (int i = 0; i < 6; i++) begin
      launch(va[i], vb[i], vo[i]);
      wait_done(edges, busy_c, moved);
      n_tests++;
      if ({Carry, Ovf, Ans} !== req[i] || edges != N_NIB || busy_c != N_NIB || moved) begin
        n_fail++;
        $display("FAIL directed_%0d: got C=%b V=%b Ans=%h edges=%0d busy=%0d moved=%b required %h edges=%0d",
                 i, Carry, Ovf, Ans, edges, busy_c, moved, req[i], N_NIB);
      end
      $display("[TB] directed %h %s %h -> Ans=%h C=%b V=%b edges=%0d", va[i], vo[i] ? "-" : "+",
               vb[i], Ans, Carry, Ovf, edges);
      @(negedge clk);
      n_tests++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_strobe_%0d: got Done=%b Busy=%b required 0 0", i, Done, Busy);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic op;
    logic [W+1:0] exp_v;
    int edges, busy_c;
    bit moved;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      op = 1'($urandom);
      if (i % 6 == 0) b = (i % 12 == 0) ? a : 16'h8000;
      exp_v = model(a, b, op);
      launch(a, b, op);
      wait_done(edges, busy_c, moved);
      n_tests++;
      if ({Carry, Ovf, Ans} !== exp_v || edges != N_NIB || moved) begin
        n_fail++;
        $display("FAIL random_%0d: %h %s %h got C=%b V=%b Ans=%h edges=%0d required %h edges=%0d",
                 i, a, op ? "-" : "+", b, Carry, Ovf, Ans, edges, exp_v, N_NIB);
      end
      $display("[TB] random %h %s %h -> Ans=%h C=%b V=%b", a, op ? "-" : "+", b, Ans, Carry, Ovf);
    end
  endtask

  task automatic test_hold_during_run;
    logic [W+1:0] exp_v;
    exp_v = model(16'h4321, 16'h1111, 1'b1);
    @(negedge clk);
    A = 16'h4321; B = 16'h1111; Op = 1'b1; Start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_busy_%0d: got Busy=%b Done=%b required 1 0", k, Busy, Done);
      end
      A = W'($urandom); B = W'($urandom); Op = 1'($urandom); Start = 1'b1;
      @(negedge clk);
    end
    Start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (Done !== 1'b1 || {Carry, Ovf, Ans} !== exp_v) begin
      n_fail++;
      $display("FAIL hold_result: got Done=%b C=%b V=%b Ans=%h required Done=1 %h",
               Done, Carry, Ovf, Ans, exp_v);
    end
    $display("[TB] hold 4321 - 1111 -> Ans=%h C=%b V=%b", Ans, Carry, Ovf);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int edges, busy_c;
    bit moved;
    launch(16'h0F0F, 16'h00F1, 1'b0);
    wait_done(edges, busy_c, moved);
    n_tests++;
    if (Done !== 1'b1 || Ans !== 16'h1000) begin
      n_fail++;
      $display("FAIL b2b_first: got Done=%b Ans=%h required 1 1000", Done, Ans);
    end
    A = 16'h0001; B = 16'h0001; Op = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n_tests++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_idle: got Busy=%b Done=%b required 1 0", Busy, Done);
    end
    wait_done(edges, busy_c, moved);
    n_tests++;
    if (edges + 1 != N_NIB + 1 || Ans !== 16'h0002 || {Carry, Ovf} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_second: got spacing=%0d Ans=%h C=%b V=%b required 5 0002 0 0",
               edges + 1, Ans, Carry, Ovf);
    end
    $display("[TB] back-to-back spacing=%0d Ans=%h", edges + 1, Ans);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int edges, busy_c;
    bit moved;
    bit saw_done;
    launch(16'h1234, 16'h5678, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({Ans, Carry, Ovf, Busy, Done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h required 0", {Ans, Carry, Ovf, Busy, Done});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (Done || Busy) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_abandon: got activity=1 required 0");
    end
    launch(16'h00FF, 16'h0001, 1'b0);
    wait_done(edges, busy_c, moved);
    n_tests++;
    if (Ans !== 16'h0100 || edges != N_NIB || {Carry, Ovf} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_restart: got Ans=%h edges=%0d C=%b V=%b required 0100 4 0 0",
               Ans, edges, Carry, Ovf);
    end
    $display("[TB] after mid-run reset 00FF + 0001 -> Ans=%h edges=%0d", Ans, edges);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gatelevel_addsub_seq.md
GATELEVEL_ADDSUB_SEQ -- requirements
Module: gatelevel_addsub_seq

Interface
REQ-001 The block SHALL have parameter N_NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB; legal N_NIB >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port Op, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-006 The block SHALL have ports A and B, inputs, W each, the operands, sampled only on accept.
REQ-007 The block SHALL have port Ans, output, W, the registered result.
REQ-008 The block SHALL have port Carry, output, 1, final carry-out; for subtraction 1 means no borrow (A >= B unsigned).
REQ-009 The block SHALL have port Ovf, output, 1, two's-complement overflow of the final result.
REQ-010 The block SHALL have port Busy, output, 1, high while nibbles are being processed.
REQ-011 The block SHALL have port Done, output, 1, one-cycle completion strobe.

Function
REQ-012 The block SHALL compute one W-bit add/sub nibble-serially through a single internal 4-bit add/sub slice (B nibble XOR Op, carry-in chained), one nibble per clock, LSB nibble first.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; Busy = (state == RUN); Done = (state == DONE); both are decoded from registered state.
REQ-014 Accept: in IDLE or DONE with Start = 1 at a rising edge, the block SHALL capture A, B and Op, set the carry register to Op, set the nibble index to 0, and enter RUN.
REQ-015 Start SHALL be ignored in RUN; operand or Op changes during RUN SHALL NOT affect the result.
REQ-016 In RUN, each edge SHALL write slice sum into shadow nibble [index], load the carry register from the slice carry-out, and increment the index; the edge that processes nibble N_NIB-1 SHALL enter DONE.
REQ-017 Latency: Done SHALL be high exactly N_NIB rising edges after the accepting edge, for exactly one clock period.
REQ-018 Ans, Carry and Ovf SHALL update only on the edge entering DONE and hold until the next entry to DONE or reset; partial results SHALL NOT be visible on Ans.
REQ-019 Ovf SHALL equal (A[W-1] XOR Ans[W-1]) AND (B'[W-1] XOR Ans[W-1]), with B' = B XOR {W{Op}} and A/B the captured operands.
REQ-020 Arithmetic SHALL be modulo 2^W; Carry is bit W of A + B' + Op.
REQ-021 From DONE with Start = 0, the block SHALL return to IDLE; with Start = 1, it SHALL accept (REQ-014) and enter RUN with no IDLE cycle, giving back-to-back Done spacing of N_NIB+1 edges.

Reset
REQ-022 While rst = 1, the block SHALL immediately, without a clock, force state IDLE, index 0, carry register 0, shadow 0, Ans 0, Carry 0, Ovf 0, Busy 0, Done 0.
REQ-023 Reset asserted mid-RUN SHALL abandon the operation with no Done; after release, the first Start SHALL be accepted normally.

Verification (N_NIB = 4, W = 16)
REQ-024 Add 0x1234 + 0x0FF1, Op=0 -> Busy 4 cycles, Done at 4th edge after accept, Ans=0x2225, Carry=0, Ovf=0.
REQ-025 Sub 0x0005 - 0x0007, Op=1 -> Ans=0xFFFE, Carry=0, Ovf=0; sub 0x8000 - 0x0001 -> Ans=0x7FFF, Carry=1, Ovf=1.
REQ-026 Add 0x7FFF + 0x0001 -> Ans=0x8000, Carry=0, Ovf=1; add 0xFFFF + 0x0001 -> Ans=0x0000, Carry=1, Ovf=0.
REQ-027 Start held high and A/B/Op changed during RUN -> result of originally captured operands, no restart; Start=1 in DONE with 0x0001+0x0001 -> second Done 5 edges after first, Ans=0x0002.
REQ-028 rst pulsed two edges into RUN -> all outputs 0 asynchronously, no Done; subsequent Start with 0x00FF+0x0001 -> Ans=0x0100 after 4 edges.
